// File: rtl/dmem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_arbiter
// Description : Round-robin arbiter sharing one data-memory load/store port
//               between the integer (INT, port 0) and floating-point
//               (FP, port 1) load/store stages. Captures the request at
//               grant, drives the memory for ACCESS_CYCLES cycles, then
//               returns a one-cycle done pulse with registered load data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_arbiter #(
    parameter int ACCESS_CYCLES = 1,
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    // INT requester
    input  logic              int_req,
    input  logic              int_we,
    input  logic [ADDR_W-1:0] int_addr,
    input  logic [DATA_W-1:0] int_wdata,
    input  logic [2:0]        int_func3,
    output logic              int_gnt,
    output logic              int_done,
    output logic [DATA_W-1:0] int_rdata,
    // FP requester
    input  logic              fp_req,
    input  logic              fp_we,
    input  logic [ADDR_W-1:0] fp_addr,
    input  logic [DATA_W-1:0] fp_wdata,
    input  logic [2:0]        fp_func3,
    output logic              fp_gnt,
    output logic              fp_done,
    output logic [DATA_W-1:0] fp_rdata,
    // Memory side
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Counter wide enough to hold ACCESS_CYCLES-1 (at least one bit)
    localparam int              CNT_W      = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic            c_port_int = 1'b0;
    localparam logic            c_port_fp  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last_grant;   // also identifies the owner of the current access
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_func3;
    logic                r_int_gnt;
    logic                r_fp_gnt;
    logic [DATA_W-1:0]   r_int_rdata;
    logic [DATA_W-1:0]   r_fp_rdata;

    logic                w_grant_valid;
    logic                w_grant_port;
    logic                w_final;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [2:0]          w_sel_func3;

    // Winner selection: a lone requester wins; on a tie the port not granted last wins
    always_comb begin
        w_grant_port = c_port_int;
        if (int_req && fp_req) begin
            w_grant_port = ~r_last_grant;
        end else if (fp_req) begin
            w_grant_port = c_port_fp;
        end
        w_grant_valid = (r_state == S_IDLE) && !halt && (int_req || fp_req);
        w_final       = (r_state == S_ACCESS) && (r_cnt == '0);
        w_sel_we      = (w_grant_port == c_port_fp) ? fp_we    : int_we;
        w_sel_addr    = (w_grant_port == c_port_fp) ? fp_addr  : int_addr;
        w_sel_wdata   = (w_grant_port == c_port_fp) ? fp_wdata : int_wdata;
        w_sel_func3   = (w_grant_port == c_port_fp) ? fp_func3 : int_func3;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_valid) w_state_next = S_ACCESS;
            S_ACCESS: if (w_final)       w_state_next = S_RESP;
            S_RESP:                      w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture, access countdown, grant pulses and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_last_grant <= c_port_fp;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_func3      <= '0;
            r_int_gnt    <= 1'b0;
            r_fp_gnt     <= 1'b0;
            r_int_rdata  <= '0;
            r_fp_rdata   <= '0;
        end else begin
            r_int_gnt <= w_grant_valid && (w_grant_port == c_port_int);
            r_fp_gnt  <= w_grant_valid && (w_grant_port == c_port_fp);
            if (w_grant_valid) begin
                r_we         <= w_sel_we;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_func3      <= w_sel_func3;
                r_last_grant <= w_grant_port;
                r_cnt        <= c_cnt_load;
            end else if ((r_state == S_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_final) begin
                if (r_last_grant == c_port_fp) begin
                    r_fp_rdata <= mem_rdata;
                end else begin
                    r_int_rdata <= mem_rdata;
                end
            end
        end
    end

    // Write strobe only in the final access cycle so each store writes exactly once
    assign mem_we    = w_final && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_func3 = r_func3;

    assign int_gnt   = r_int_gnt;
    assign fp_gnt    = r_fp_gnt;
    assign int_done  = (r_state == S_RESP) && (r_last_grant == c_port_int);
    assign fp_done   = (r_state == S_RESP) && (r_last_grant == c_port_fp);
    assign int_rdata = r_int_rdata;
    assign fp_rdata  = r_fp_rdata;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_access_arbiter
// Description : Self-checking bench for dmem_access_arbiter. Three instances
//               with ACCESS_CYCLES = 1, 2, 3; a scoreboard of expected done
//               responses and memory writes is checked as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_arbiter;

    localparam int   N_DUT = 3;
    localparam logic P_INT = 1'b0;
    localparam logic P_FP  = 1'b1;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } done_exp_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] wdata;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;

    logic        int_req   [N_DUT];
    logic        int_we    [N_DUT];
    logic [7:0]  int_addr  [N_DUT];
    logic [31:0] int_wdata [N_DUT];
    logic [2:0]  int_func3 [N_DUT];
    logic        int_gnt   [N_DUT];
    logic        int_done  [N_DUT];
    logic [31:0] int_rdata [N_DUT];
    logic        fp_req    [N_DUT];
    logic        fp_we     [N_DUT];
    logic [7:0]  fp_addr   [N_DUT];
    logic [31:0] fp_wdata  [N_DUT];
    logic [2:0]  fp_func3  [N_DUT];
    logic        fp_gnt    [N_DUT];
    logic        fp_done   [N_DUT];
    logic [31:0] fp_rdata  [N_DUT];
    logic        mem_we    [N_DUT];
    logic [7:0]  mem_addr  [N_DUT];
    logic [31:0] mem_wdata [N_DUT];
    logic [2:0]  mem_func3 [N_DUT];
    logic [31:0] mem_rdata [N_DUT];
    logic        busy      [N_DUT];

    logic        use_fixed   [N_DUT];
    logic [31:0] fixed_rdata [N_DUT];

    done_exp_t done_q[$];
    wr_exp_t   wr_q[$];
    done_exp_t mon_d;
    wr_exp_t   mon_w;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int cur      = 0;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        dmem_access_arbiter #(
            .ACCESS_CYCLES(g + 1),
            .ADDR_W       (8),
            .DATA_W       (32)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .halt     (halt),
            .int_req  (int_req[g]),
            .int_we   (int_we[g]),
            .int_addr (int_addr[g]),
            .int_wdata(int_wdata[g]),
            .int_func3(int_func3[g]),
            .int_gnt  (int_gnt[g]),
            .int_done (int_done[g]),
            .int_rdata(int_rdata[g]),
            .fp_req   (fp_req[g]),
            .fp_we    (fp_we[g]),
            .fp_addr  (fp_addr[g]),
            .fp_wdata (fp_wdata[g]),
            .fp_func3 (fp_func3[g]),
            .fp_gnt   (fp_gnt[g]),
            .fp_done  (fp_done[g]),
            .fp_rdata (fp_rdata[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_func3(mem_func3[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Memory model: either a forced value or a pattern derived from the address
    always_comb begin
        for (int k = 0; k < N_DUT; k++) begin
            mem_rdata[k] = use_fixed[k] ? fixed_rdata[k]
                                        : {mem_addr[k], 8'h5A, ~mem_addr[k], 8'hC3};
        end
    end

    // Scoreboard: compare done responses and memory writes of the active instance
    always @(negedge clk) begin
        if (int_done[cur] || fp_done[cur]) begin
            checks++;
            if (int_done[cur] && fp_done[cur]) begin
                failures++;
                $display("FAIL done_both dut=%0d int_done=1 fp_done=1 required=one port", cur);
            end else if (done_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected dut=%0d int_done=%0b fp_done=%0b required=no done",
                         cur, int_done[cur], fp_done[cur]);
            end else begin
                mon_d = done_q.pop_front();
                if (fp_done[cur] !== mon_d.port ||
                    (fp_done[cur] ? fp_rdata[cur] : int_rdata[cur]) !== mon_d.rdata) begin
                    failures++;
                    $display("FAIL done_data dut=%0d port=%0b rdata=%h required port=%0b rdata=%h",
                             cur, fp_done[cur], fp_done[cur] ? fp_rdata[cur] : int_rdata[cur],
                             mon_d.port, mon_d.rdata);
                end
            end
        end
        if (mem_we[cur] === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected dut=%0d addr=%h wdata=%h required=no write",
                         cur, mem_addr[cur], mem_wdata[cur]);
            end else begin
                mon_w = wr_q.pop_front();
                if (mem_addr[cur] !== mon_w.addr || mem_wdata[cur] !== mon_w.wdata) begin
                    failures++;
                    $display("FAIL write_data dut=%0d addr=%h wdata=%h required addr=%h wdata=%h",
                             cur, mem_addr[cur], mem_wdata[cur], mon_w.addr, mon_w.wdata);
                end
            end
        end
    end

    task automatic idle_inputs();
        for (int k = 0; k < N_DUT; k++) begin
            int_req[k] = 0; int_we[k] = 0; int_addr[k] = '0; int_wdata[k] = '0; int_func3[k] = '0;
            fp_req[k]  = 0; fp_we[k]  = 0; fp_addr[k]  = '0; fp_wdata[k]  = '0; fp_func3[k]  = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        halt  = 1'b0;
        idle_inputs();
        for (int k = 0; k < N_DUT; k++) begin
            use_fixed[k]   = 1'b1;
            fixed_rdata[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            checks++;
            if ({int_gnt[k], int_done[k], fp_gnt[k], fp_done[k], mem_we[k], busy[k]} !== 6'b0 ||
                mem_addr[k] !== 8'h0 || mem_wdata[k] !== 32'h0 || mem_func3[k] !== 3'b0 ||
                int_rdata[k] !== 32'h0 || fp_rdata[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d gnt=%b%b done=%b%b we=%b busy=%b addr=%h wdata=%h rdata=%h/%h required=all zero",
                         k, int_gnt[k], fp_gnt[k], int_done[k], fp_done[k], mem_we[k], busy[k],
                         mem_addr[k], mem_wdata[k], int_rdata[k], fp_rdata[k]);
            end
        end
    endtask

    task automatic test_int_load();
        cur = 0;
        use_fixed[0]   = 1'b1;
        fixed_rdata[0] = 32'hDEADBEEF;
        @(posedge clk); #1;
        int_req[0] = 1; int_we[0] = 0; int_addr[0] = 8'h10;
        int_wdata[0] = 32'h12345678; int_func3[0] = 3'b010;
        done_q.push_back(done_exp_t'{port: P_INT, rdata: 32'hDEADBEEF});
        @(negedge clk); // cycle N
        checks++;
        if (int_gnt[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_early_gnt gnt=%b busy=%b required gnt=0 busy=0", int_gnt[0], busy[0]);
        end
        @(negedge clk); // cycle N+1
        checks++;
        if (int_gnt[0] !== 1'b1 || fp_gnt[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_gnt int_gnt=%b fp_gnt=%b required 1/0", int_gnt[0], fp_gnt[0]);
        end
        checks++;
        if (mem_we[0] !== 1'b0 || mem_addr[0] !== 8'h10 || mem_func3[0] !== 3'b010 || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL load_access we=%b addr=%h func3=%b busy=%b required we=0 addr=10 func3=010 busy=1",
                     mem_we[0], mem_addr[0], mem_func3[0], busy[0]);
        end
        int_req[0] = 0;
        @(negedge clk); // cycle N+2
        checks++;
        if (int_done[0] !== 1'b1 || int_gnt[0] !== 1'b0 || mem_we[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_done done=%b gnt=%b we=%b required done=1 gnt=0 we=0",
                     int_done[0], int_gnt[0], mem_we[0]);
        end
        fixed_rdata[0] = 32'h0;
        @(negedge clk);
        checks++;
        if (int_done[0] !== 1'b0 || busy[0] !== 1'b0 || int_rdata[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL load_hold done=%b busy=%b rdata=%h required done=0 busy=0 rdata=deadbeef",
                     int_done[0], busy[0], int_rdata[0]);
        end
        checks++;
        if (done_q.size() != 0) begin
            failures++;
            $display("FAIL load_drain pending=%0d required=0", done_q.size());
        end
    endtask

    task automatic test_fp_store();
        int we_cnt  = 0;
        int we_at   = -1;
        int done_at = -1;
        cur = 0;
        fixed_rdata[0] = 32'h0BADF00D;
        @(posedge clk); #1;
        fp_req[0] = 1; fp_we[0] = 1; fp_addr[0] = 8'h20;
        fp_wdata[0] = 32'h3F800000; fp_func3[0] = 3'b010;
        wr_q.push_back(wr_exp_t'{addr: 8'h20, wdata: 32'h3F800000});
        done_q.push_back(done_exp_t'{port: P_FP, rdata: 32'h0BADF00D});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fp_gnt[0] === 1'b1) fp_req[0] = 0;
            if (mem_we[0] === 1'b1) begin we_cnt++; we_at = i; end
            if (fp_done[0] === 1'b1) done_at = i;
        end
        checks++;
        if (we_cnt != 1 || we_at != 1) begin
            failures++;
            $display("FAIL store_we_pulse count=%0d at=%0d required count=1 at=1", we_cnt, we_at);
        end
        checks++;
        if (done_at != we_at + 1) begin
            failures++;
            $display("FAIL store_done_timing done_at=%0d required=%0d", done_at, we_at + 1);
        end
        checks++;
        if (done_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL store_drain pending done=%0d wr=%0d required 0/0", done_q.size(), wr_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] gv [4];
        int         gc [4];
        int         n_g = 0;
        cur = 0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        use_fixed[0] = 1'b0;
        int_req[0] = 1; int_we[0] = 0; int_addr[0] = 8'h40; int_func3[0] = 3'b010;
        fp_req[0]  = 1; fp_we[0]  = 0; fp_addr[0]  = 8'h80; fp_func3[0]  = 3'b010;
        for (int i = 0; i < 2; i++) begin
            done_q.push_back(done_exp_t'{port: P_INT, rdata: {8'h40, 8'h5A, 8'hBF, 8'hC3}});
            done_q.push_back(done_exp_t'{port: P_FP,  rdata: {8'h80, 8'h5A, 8'h7F, 8'hC3}});
        end
        for (int i = 0; i < 20 && n_g < 4; i++) begin
            @(negedge clk);
            if (int_gnt[0] === 1'b1 || fp_gnt[0] === 1'b1) begin
                gv[n_g] = {int_gnt[0], fp_gnt[0]};
                gc[n_g] = cycle;
                n_g++;
            end
        end
        int_req[0] = 0;
        fp_req[0]  = 0;
        checks++;
        if (n_g != 4) begin
            failures++;
            $display("FAIL rr_grant_count grants=%0d required=4", n_g);
        end
        for (int i = 0; i < n_g; i++) begin
            checks++;
            if (gv[i] !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rr_order idx=%0d int_fp_gnt=%b required=%b", i, gv[i],
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i > 0) begin
                checks++;
                if (gc[i] - gc[i-1] != 3) begin
                    failures++;
                    $display("FAIL rr_spacing idx=%0d gap=%0d required=3", i, gc[i] - gc[i-1]);
                end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_q.size() != 0) begin
            failures++;
            $display("FAIL rr_drain pending=%0d required=0", done_q.size());
        end
    endtask

    task automatic test_halt();
        cur = 0;
        use_fixed[0]   = 1'b1;
        fixed_rdata[0] = 32'h77665544;
        @(posedge clk); #1;
        halt = 1'b1;
        int_req[0] = 1; int_we[0] = 0; int_addr[0] = 8'h33; int_func3[0] = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (int_gnt[0] !== 1'b0 || fp_gnt[0] !== 1'b0 || mem_we[0] !== 1'b0 || busy[0] !== 1'b0) begin
                failures++;
                $display("FAIL halt_blocks cyc=%0d gnt=%b%b we=%b busy=%b required all 0",
                         i, int_gnt[0], fp_gnt[0], mem_we[0], busy[0]);
            end
        end
        halt = 1'b0;
        done_q.push_back(done_exp_t'{port: P_INT, rdata: 32'h77665544});
        @(negedge clk);
        checks++;
        if (int_gnt[0] !== 1'b1) begin
            failures++;
            $display("FAIL halt_release_gnt int_gnt=%b required=1", int_gnt[0]);
        end
        int_req[0] = 0;
        repeat (2) @(negedge clk);
        // store granted, then halt rises during its access
        fp_req[0] = 1; fp_we[0] = 1; fp_addr[0] = 8'h44;
        fp_wdata[0] = 32'hA5A55A5A; fp_func3[0] = 3'b000;
        wr_q.push_back(wr_exp_t'{addr: 8'h44, wdata: 32'hA5A55A5A});
        done_q.push_back(done_exp_t'{port: P_FP, rdata: 32'h77665544});
        @(posedge clk); #1;
        halt = 1'b1;
        int_req[0] = 1;
        @(negedge clk);
        checks++;
        if (fp_gnt[0] !== 1'b1 || mem_we[0] !== 1'b1) begin
            failures++;
            $display("FAIL halt_store_write gnt=%b we=%b required gnt=1 we=1", fp_gnt[0], mem_we[0]);
        end
        fp_req[0] = 0;
        @(negedge clk);
        checks++;
        if (fp_done[0] !== 1'b1) begin
            failures++;
            $display("FAIL halt_store_done fp_done=%b required=1", fp_done[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (int_gnt[0] !== 1'b0 || busy[0] !== 1'b0) begin
                failures++;
                $display("FAIL halt_after_store cyc=%0d int_gnt=%b busy=%b required 0/0",
                         i, int_gnt[0], busy[0]);
            end
        end
        int_req[0] = 0;
        halt = 1'b0;
        checks++;
        if (done_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL halt_drain pending done=%0d wr=%0d required 0/0", done_q.size(), wr_q.size());
        end
    endtask

    task automatic test_long_access();
        cur = 2;
        use_fixed[2]   = 1'b1;
        fixed_rdata[2] = 32'h0;
        @(posedge clk); #1;
        fp_req[2] = 1; fp_we[2] = 0; fp_addr[2] = 8'h5C; fp_func3[2] = 3'b100;
        done_q.push_back(done_exp_t'{port: P_FP, rdata: 32'hCAFEF00D});
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            fixed_rdata[2] = (i == 3) ? 32'hCAFEF00D : 32'(i);
            @(negedge clk);
            if (i <= 3) begin
                checks++;
                if (fp_gnt[2] !== (i == 1) || mem_addr[2] !== 8'h5C || mem_func3[2] !== 3'b100 ||
                    mem_we[2] !== 1'b0 || busy[2] !== 1'b1 || fp_done[2] !== 1'b0) begin
                    failures++;
                    $display("FAIL long_access cyc=%0d gnt=%b addr=%h func3=%b we=%b busy=%b done=%b required gnt=%0b addr=5c func3=100 we=0 busy=1 done=0",
                             i, fp_gnt[2], mem_addr[2], mem_func3[2], mem_we[2], busy[2], fp_done[2], i == 1);
                end
                fp_req[2] = 0;
            end else begin
                checks++;
                if (fp_done[2] !== 1'b1) begin
                    failures++;
                    $display("FAIL long_done fp_done=%b required=1 at N+4", fp_done[2]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done_q.size() != 0 || fp_rdata[2] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL long_drain pending=%0d rdata=%h required 0 cafef00d", done_q.size(), fp_rdata[2]);
        end
    endtask

    task automatic test_reset_mid();
        int   evt = 0;
        logic got = 1'b0;
        cur = 1;
        use_fixed[1]   = 1'b1;
        fixed_rdata[1] = 32'h13572468;
        @(posedge clk); #1;
        int_req[1] = 1; int_we[1] = 1; int_addr[1] = 8'h66;
        int_wdata[1] = 32'h99887766; int_func3[1] = 3'b010;
        @(posedge clk); #1;
        reset = 1'b1;
        int_req[1] = 0;
        @(negedge clk);
        checks++;
        if (int_gnt[1] !== 1'b1 || mem_we[1] !== 1'b0) begin
            failures++;
            $display("FAIL mid_first_access gnt=%b we=%b required gnt=1 we=0", int_gnt[1], mem_we[1]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({int_gnt[1], int_done[1], fp_gnt[1], fp_done[1], mem_we[1], busy[1]} !== 6'b0 ||
            mem_addr[1] !== 8'h0 || mem_wdata[1] !== 32'h0 || mem_func3[1] !== 3'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs gnt=%b%b done=%b%b we=%b busy=%b addr=%h wdata=%h required all zero",
                     int_gnt[1], fp_gnt[1], int_done[1], fp_done[1], mem_we[1], busy[1],
                     mem_addr[1], mem_wdata[1]);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_we[1] === 1'b1 || int_done[1] === 1'b1 || fp_done[1] === 1'b1) evt++;
        end
        checks++;
        if (evt != 0) begin
            failures++;
            $display("FAIL mid_no_activity events=%0d required=0", evt);
        end
        int_req[1] = 1; int_we[1] = 0; int_addr[1] = 8'h01;
        fp_req[1]  = 1; fp_we[1]  = 0; fp_addr[1]  = 8'h02;
        done_q.push_back(done_exp_t'{port: P_INT, rdata: 32'h13572468});
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (int_gnt[1] === 1'b1 || fp_gnt[1] === 1'b1) begin
                got = 1'b1;
                checks++;
                if (int_gnt[1] !== 1'b1 || fp_gnt[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_tie_winner int_gnt=%b fp_gnt=%b required 1/0", int_gnt[1], fp_gnt[1]);
                end
            end
        end
        int_req[1] = 0;
        fp_req[1]  = 0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL mid_tie_timeout gnt=none required=int_gnt");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_q.size() != 0) begin
            failures++;
            $display("FAIL mid_drain pending=%0d required=0", done_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_int_load();
        test_fp_store();
        test_round_robin();
        test_halt();
        test_long_access();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required=finish earlier", $time);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
